// File: rtl/program_load_sequencer_if.sv
// Host byte stream and instruction-memory write bus for the program load
// sequencer.
//   host_valid/host_byte/host_last : byte stream from host (valid/ready)
//   host_ready                     : sequencer can take a byte this cycle
//   I_MEM_Write_Enable/Data_In/Addr: word write port into the datapath I_MEM
// master = host/bench side, slave = sequencer side.
interface program_load_sequencer_if;
    logic        host_valid;
    logic [7:0]  host_byte;
    logic        host_last;
    logic        host_ready;
    logic        I_MEM_Write_Enable;
    logic [31:0] I_MEM_Data_In;
    logic [15:0] I_MEM_Write_Addr;

    modport master (
        output host_valid, host_byte, host_last,
        input  host_ready, I_MEM_Write_Enable, I_MEM_Data_In, I_MEM_Write_Addr
    );

    modport slave (
        input  host_valid, host_byte, host_last,
        output host_ready, I_MEM_Write_Enable, I_MEM_Data_In, I_MEM_Write_Addr
    );
endinterface

// File: rtl/program_load_sequencer.sv
// Program load sequencer: packs a host byte stream (big-endian) into 32-bit
// words, writes them to instruction memory, pulses the datapath start, then
// watches PC_out for HALT_PC or a cycle budget and captures ALUOut at halt.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : host byte stream + I_MEM write port
//   clear           : leave DONE back to IDLE
//   PC_out, ALUOut  : datapath observation
//   start           : datapath start (high in ARM)
//   busy            : not IDLE and not DONE
//   done/timeout/load_err : completion status, held in DONE
//   result          : ALUOut captured at halt
//   words_loaded    : number of words written
module program_load_sequencer #(
    parameter logic [31:0] HALT_PC        = 32'h0000_00FF,
    parameter int          MAX_RUN_CYCLES = 4096,
    parameter int          MAX_WORDS      = 1024,
    parameter int          START_CYCLES   = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    program_load_sequencer_if.slave         bus,
    input  logic                            clear,
    input  logic [31:0]                     PC_out,
    input  logic [31:0]                     ALUOut,
    output logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic                            timeout,
    output logic                            load_err,
    output logic [31:0]                     result,
    output logic [15:0]                     words_loaded
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_ARM   = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]  state;
    logic [1:0]  byte_cnt;
    logic [16:0] word_ptr;     // one bit wider than the address so it can reach MAX_WORDS
    logic [31:0] run_cnt;
    logic [31:0] shreg;
    logic        last_word;    // word being written carried host_last
    logic [31:0] wdata;
    logic [15:0] waddr;
    logic        accept;
    logic [31:0] word_nxt;

    assign bus.host_ready         = (state == S_IDLE) || (state == S_LOAD);
    assign bus.I_MEM_Write_Enable = (state == S_WRITE);
    assign bus.I_MEM_Data_In      = wdata;
    assign bus.I_MEM_Write_Addr   = waddr;
    assign start                  = (state == S_ARM);
    assign busy                   = (state != S_IDLE) && (state != S_DONE);

    assign accept   = bus.host_valid && bus.host_ready;
    // Lane n sits at bits [31-8n -: 8]; shift by 8*(3-byte_cnt).
    assign word_nxt = shreg | ({24'd0, bus.host_byte} << {~byte_cnt, 3'b000});

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            byte_cnt     <= '0;
            word_ptr     <= '0;
            run_cnt      <= '0;
            shreg        <= '0;
            last_word    <= 1'b0;
            wdata        <= '0;
            waddr        <= '0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            load_err     <= 1'b0;
            result       <= '0;
            words_loaded <= '0;
        end else begin
            case (state)
                S_IDLE, S_LOAD: begin
                    if (accept) begin
                        // word_ptr only moves in WRITE, so a full memory is
                        // always detected on the first byte of a new word.
                        if (state == S_LOAD && word_ptr == 17'(MAX_WORDS)) begin
                            load_err <= 1'b1;
                            state    <= S_DONE;
                        end else if (byte_cnt == 2'd3 || bus.host_last) begin
                            wdata     <= word_nxt;
                            waddr     <= word_ptr[15:0];
                            last_word <= bus.host_last;
                            state     <= S_WRITE;
                        end else begin
                            shreg    <= word_nxt;
                            byte_cnt <= byte_cnt + 2'd1;
                            state    <= S_LOAD;
                        end
                    end
                end
                S_WRITE: begin
                    word_ptr     <= word_ptr + 17'd1;
                    words_loaded <= word_ptr[15:0] + 16'd1;
                    shreg        <= '0;
                    byte_cnt     <= '0;
                    run_cnt      <= '0;
                    state        <= last_word ? S_ARM : S_LOAD;
                end
                S_ARM: begin
                    if (run_cnt == 32'(START_CYCLES - 1)) begin
                        run_cnt <= '0;
                        state   <= S_RUN;
                    end else begin
                        run_cnt <= run_cnt + 32'd1;
                    end
                end
                S_RUN: begin
                    // Halt is checked first so it wins over a same-cycle timeout.
                    if (PC_out == HALT_PC) begin
                        result  <= ALUOut;
                        done    <= 1'b1;
                        run_cnt <= '0;
                        state   <= S_DONE;
                    end else if (run_cnt == 32'(MAX_RUN_CYCLES - 1)) begin
                        timeout <= 1'b1;
                        run_cnt <= '0;
                        state   <= S_DONE;
                    end else begin
                        run_cnt <= run_cnt + 32'd1;
                    end
                end
                S_DONE: begin
                    if (clear) begin
                        done     <= 1'b0;
                        timeout  <= 1'b0;
                        load_err <= 1'b0;
                        word_ptr <= '0;
                        shreg    <= '0;
                        byte_cnt <= '0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_program_load_sequencer.sv
// Directed bench: dut0 (MAX_WORDS=2, MAX_RUN_CYCLES=64) and dut1
// (MAX_RUN_CYCLES=16) see identical stimulus; dut1 exists for the short
// timeout budget.
module tb_program_load_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [31:0] pc, alu;
    always #5 clk = ~clk;

    program_load_sequencer_if if0 ();
    program_load_sequencer_if if1 ();
    assign if1.host_valid = if0.host_valid;
    assign if1.host_byte  = if0.host_byte;
    assign if1.host_last  = if0.host_last;

    logic        start0, busy0, done0, to0, le0;
    logic [31:0] res0;
    logic [15:0] wl0;
    logic        start1, busy1, done1, to1, le1;
    logic [31:0] res1;
    logic [15:0] wl1;

    program_load_sequencer #(.MAX_WORDS(2), .MAX_RUN_CYCLES(64)) dut0 (
        .clk(clk), .rst(rst), .bus(if0), .clear(clear), .PC_out(pc), .ALUOut(alu),
        .start(start0), .busy(busy0), .done(done0), .timeout(to0), .load_err(le0),
        .result(res0), .words_loaded(wl0));

    program_load_sequencer #(.MAX_RUN_CYCLES(16)) dut1 (
        .clk(clk), .rst(rst), .bus(if1), .clear(clear), .PC_out(pc), .ALUOut(alu),
        .start(start1), .busy(busy1), .done(done1), .timeout(to1), .load_err(le1),
        .result(res1), .words_loaded(wl1));

    // Write log {addr, data} and handshake observations, sampled mid-cycle.
    logic [47:0] wq[$];
    int          ready_in_write = 0;
    int          start_cyc = 0;
    always @(negedge clk) begin
        if (if0.I_MEM_Write_Enable) begin
            wq.push_back({if0.I_MEM_Write_Addr, if0.I_MEM_Data_In});
            if (if0.host_ready) ready_in_write++;
        end
        if (start0) start_cyc++;
    end

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        int n = 0;
        if0.host_valid = 1'b1;
        if0.host_byte  = b;
        if0.host_last  = last;
        while (!if0.host_ready && n < 20) begin
            tick(1);
            n++;
        end
        if (!if0.host_ready) chk("send_ready_wait", 48'(if0.host_ready), 48'd1);
        else tick(1);
        if0.host_valid = 1'b0;
        if0.host_last  = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!start0 && n < 20) begin
            tick(1);
            n++;
        end
        chk(tag, 48'(start0), 48'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, 48'(if0.host_ready), 48'd1);
        chk({tag, "_busy"},  48'(busy0), 48'd0);
        chk({tag, "_start"}, 48'(start0), 48'd0);
        chk({tag, "_flags"}, 48'({done0, to0, le0}), 48'd0);
        chk({tag, "_result"}, 48'(res0), 48'd0);
        chk({tag, "_wl"},    48'(wl0), 48'd0);
        chk({tag, "_wbus"},  {15'd0, if0.I_MEM_Write_Enable, if0.I_MEM_Data_In},
            48'd0);
        chk({tag, "_waddr"}, 48'(if0.I_MEM_Write_Addr), 48'd0);
    endtask

    initial begin
        int b0, s0, r0;
        logic [7:0] p1 [8];
        p1 = '{8'h20, 8'h41, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'hFF};

        rst = 1'b1; clear = 1'b0; pc = '0; alu = '0;
        if0.host_valid = 1'b0; if0.host_byte = '0; if0.host_last = 1'b0;
        tick(2);
        rst = 1'b0;
        chk_reset("por");

        // Two-word program, halt at RUN cycle 37.
        b0 = wq.size(); s0 = start_cyc;
        for (int i = 0; i < 8; i++) begin
            send(p1[i], i == 7);
            if (i == 3) begin
                chk("t1_we_w0", 48'(if0.I_MEM_Write_Enable), 48'd1);
                chk("t1_ready_w0", 48'(if0.host_ready), 48'd0);
            end
        end
        wait_start("t1_start");
        chk("t1_nwr", 48'(wq.size() - b0), 48'd2);
        chk("t1_w0", wq[b0], {16'd0, 32'h2041_0005});
        chk("t1_w1", wq[b0+1], {16'd1, 32'h0000_00FF});
        chk("t1_wl", 48'(wl0), 48'd2);
        alu = 32'h1234;
        tick(1);
        chk("t1_start_len", 48'(start_cyc - s0), 48'd1);
        chk("t1_run_busy", 48'({busy0, start0}), 48'b10);
        tick(37);
        chk("t1_not_done", 48'(done0), 48'd0);
        pc = 32'hFF;
        tick(1);
        pc = '0;
        chk("t1_done", 48'({done0, to0, busy0}), 48'b100);
        chk("t1_result", 48'(res0), 48'h1234);
        clear = 1'b1; tick(1); clear = 1'b0;
        chk("t1_clr", 48'({busy0, done0, if0.host_ready}), 48'b001);
        chk("t1_clr_res", 48'(res0), 48'h1234);
        chk("t1_clr_wl", 48'(wl0), 48'd2);

        // Five bytes, last byte padded; then timeout on both budgets.
        b0 = wq.size(); r0 = ready_in_write;
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
        chk("t2_ready_w0", 48'(if0.host_ready), 48'd0);
        send(8'hAB, 1'b1);
        chk("t2_we_w1", 48'({if0.I_MEM_Write_Enable, if0.host_ready}), 48'b10);
        wait_start("t2_start");
        chk("t2_w0", wq[b0], {16'd0, 32'h1122_3344});
        chk("t2_w1", wq[b0+1], {16'd1, 32'hAB00_0000});
        chk("t2_ready_in_wr", 48'(ready_in_write - r0), 48'd0);
        tick(1);
        tick(15);
        chk("t2_to1_early", 48'({to1, busy1}), 48'b01);
        tick(1);
        chk("t2_to1", 48'({to1, done1, busy1}), 48'b100);
        chk("t2_res1", 48'(res1), 48'd0);
        tick(47);
        chk("t2_to0_early", 48'({to0, busy0}), 48'b01);
        tick(1);
        chk("t2_to0", 48'({to0, done0}), 48'b10);
        chk("t2_res0_kept", 48'(res0), 48'h1234);
        clear = 1'b1; tick(1); clear = 1'b0;

        // Three full words into a two-word memory.
        b0 = wq.size();
        for (int i = 1; i <= 9; i++) send(8'(i), 1'b0);
        chk("t3_le", 48'({le0, done0, busy0, if0.host_ready}), 48'b1000);
        tick(3);
        chk("t3_nwr", 48'(wq.size() - b0), 48'd2);
        chk("t3_w1", wq[b0+1], {16'd1, 32'h0506_0708});
        clear = 1'b1; tick(1); clear = 1'b0;
        chk("t3_clr_le", 48'(le0), 48'd0);

        // Reset in LOAD, RUN and WRITE.
        send(8'hDE, 1'b0); send(8'hAD, 1'b0);
        rst = 1'b1; tick(1); rst = 1'b0;
        chk_reset("rst_load");
        send(8'h77, 1'b1);
        wait_start("t4_start");
        tick(4);
        chk("t4_run_busy", 48'(busy0), 48'd1);
        rst = 1'b1; tick(1); rst = 1'b0;
        chk_reset("rst_run");
        send(8'hCA, 1'b0); send(8'hFE, 1'b0); send(8'hBA, 1'b0); send(8'hBE, 1'b0);
        chk("t4_in_write", 48'(if0.I_MEM_Write_Enable), 48'd1);
        rst = 1'b1; tick(1); rst = 1'b0;
        chk_reset("rst_write");

        b0 = wq.size();
        send(8'h12, 1'b0); send(8'h34, 1'b0); send(8'h56, 1'b0); send(8'h78, 1'b1);
        tick(1);
        chk("t5_w0", wq[b0], {16'd0, 32'h1234_5678});
        chk("t5_wl", 48'(wl0), 48'd1);
        wait_start("t5_start");
        tick(1);
        alu = 32'hBEEF; pc = 32'hFF;
        tick(1);
        pc = '0;
        chk("t5_done", 48'({done0, to0}), 48'b10);
        chk("t5_result", 48'(res0), 48'hBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/program_load_sequencer.md
Name: program_load_sequencer

Overview:
Host-side controller for the multicycle CPU datapath. It accepts a program as a byte stream over a valid/ready handshake and packs it into 32-bit words. It writes those words into instruction memory through the datapath's I_MEM write port, then pulses the datapath start input. While the core runs, it watches the PC for a halt address or a cycle timeout and captures the final ALU result for the host.

Parameters:
HALT_PC, 32'h0000_00FF, PC value that marks program completion
MAX_RUN_CYCLES, 4096, RUN-state cycle budget before timeout (>=2)
MAX_WORDS, 1024, instruction memory capacity in words (<=65536)
START_CYCLES, 1, number of cycles start is held high

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
host_valid  input  1  host byte valid
host_byte  input  8  program byte, big-endian within word (first byte -> [31:24])
host_last  input  1  qualifies final byte of program
host_ready  output  1  sequencer can accept a byte this cycle
clear  input  1  return from DONE to IDLE
PC_out  input  32  datapath PC
ALUOut  input  32  datapath ALU register output
I_MEM_Write_Enable  output  1  instruction memory write strobe
I_MEM_Data_In  output  32  word to write
I_MEM_Write_Addr  output  16  word address
start  output  1  datapath start
busy  output  1  high in any state except IDLE and DONE
done  output  1  program halted normally
timeout  output  1  run budget exhausted
load_err  output  1  program exceeded MAX_WORDS
result  output  32  ALUOut captured at halt
words_loaded  output  16  count of words written

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled on the rising edge; it overrides all other inputs.
- Reset state: FSM=IDLE, byte_cnt=0, word_ptr=0, run_cnt=0. All outputs are 0, except host_ready=1.
- States: IDLE, LOAD, WRITE, ARM, RUN, DONE.
- Byte acceptance: a byte is accepted when host_valid && host_ready at the clock edge.
- host_ready: 1 in IDLE and LOAD; 0 in all other states.
- IDLE: the first accepted byte goes into the shift register at [31:24], byte_cnt=1, next state LOAD.
- LOAD byte placement: each accepted byte goes to lane byte_cnt (lane 0 = [31:24], lane 3 = [7:0]), then byte_cnt increments.
- LOAD exit: on accepting the 4th byte, or any byte with host_last=1, go to WRITE. Unfilled lanes are zero-padded.
- host_last on the 1st byte of a word: the word is written with only [31:24] populated.
- WRITE (exactly 1 cycle):
  - I_MEM_Write_Enable=1, I_MEM_Data_In=packed word, I_MEM_Write_Addr=word_ptr[15:0].
  - Next cycle: word_ptr increments and words_loaded=word_ptr+1; shift register and byte_cnt clear.
  - If the word carried host_last, go to ARM; otherwise return to LOAD.
- Write outputs outside WRITE: I_MEM_Write_Enable=0. I_MEM_Data_In and I_MEM_Write_Addr hold their last values.
- Capacity overflow: if a byte is accepted in LOAD while word_ptr==MAX_WORDS, no write occurs. load_err=1 and the FSM goes to DONE.
- ARM: start=1 for START_CYCLES cycles, counted by run_cnt, then run_cnt=0 and go to RUN. start=0 in every other state.
- RUN: run_cnt increments each cycle.
  - If PC_out==HALT_PC: result<=ALUOut, done=1, go to DONE.
  - Else if run_cnt==MAX_RUN_CYCLES-1: timeout=1, go to DONE, result unchanged.
  - Halt takes priority over timeout in the same cycle.
- DONE: done, timeout, load_err and result hold.
  - clear=1 goes to IDLE, clears the done/timeout/load_err flags and resets word_ptr=0.
  - result and words_loaded are retained until the next WRITE or halt capture.
- clear outside DONE is ignored.
- host_valid while host_ready=0 is not consumed; the host must hold the byte.
- rst mid-operation (any state): immediate return to reset state next edge. No partial write is issued. start drops the same edge.
- busy = (state != IDLE) && (state != DONE).

Test Plan:
- 8 bytes 0x20,0x41,0x00,0x05, 0x00,0x00,0x00,0xFF (last on byte 8) -> writes: addr 0 = 0x20410005, addr 1 = 0x000000FF; words_loaded=2; then start=1 for 1 cycle.
- 5 bytes, host_last on the 5th byte 0xAB -> addr 1 = 0xAB000000 (zero-padded); host_ready low during each WRITE cycle.
- RUN with PC_out driven to 0xFF at cycle 37 and ALUOut=0x1234 -> done=1, result=0x1234, timeout=0; clear -> IDLE, busy=0, result stays 0x1234.
- RUN with PC never reaching HALT_PC, MAX_RUN_CYCLES=16 -> timeout=1 exactly 16 cycles after RUN entry, done=0.
- MAX_WORDS=2, 3 full words streamed -> two writes, then load_err=1, no third I_MEM_Write_Enable pulse.
- rst asserted in cycle 2 of LOAD, then in RUN, then in the WRITE cycle -> next edge all outputs 0, host_ready=1, and the subsequent program loads from addr 0.
